// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the IF/ID/EX hazard sequencer.
package hazard_ctrl_pkg;
  localparam int REG_ADDR_W = 4;

  typedef logic [4:0] opcode_t;
  localparam opcode_t OP_NOP  = 5'h1f;
  localparam opcode_t OP_LOAD = 5'h08;
  localparam opcode_t OP_MUL  = 5'h0c;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    MC_WAIT = 2'd2
  } haz_state_t;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute observation bus and pipeline control outputs of the hazard sequencer.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(parameter int CNT_W = 16);
  opcode_t               IFID_OPCODE;
  logic [REG_ADDR_W-1:0] IFID_R1_ADDR;
  logic [REG_ADDR_W-1:0] IFID_R2_ADDR;
  opcode_t               IDEX_OPCODE;
  logic [2:0]            IDEX_RD_ADDR;
  logic                  BRANCH_TAKEN;
  logic                  PC_WE;
  logic                  IFID_STALL;
  logic                  IFID_FLUSH;
  logic                  IDEX_FLUSH;
  logic                  EX_HOLD;
  logic [1:0]            HAZ_STATE;
  logic [CNT_W-1:0]      STALL_CNT;

  modport master (
    output IFID_OPCODE, IFID_R1_ADDR, IFID_R2_ADDR, IDEX_OPCODE, IDEX_RD_ADDR, BRANCH_TAKEN,
    input  PC_WE, IFID_STALL, IFID_FLUSH, IDEX_FLUSH, EX_HOLD, HAZ_STATE, STALL_CNT
  );
  modport slave (
    input  IFID_OPCODE, IFID_R1_ADDR, IFID_R2_ADDR, IDEX_OPCODE, IDEX_RD_ADDR, BRANCH_TAKEN,
    output PC_WE, IFID_STALL, IFID_FLUSH, IDEX_FLUSH, EX_HOLD, HAZ_STATE, STALL_CNT
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (clr)                 q <= '0;
    else if (en && q != '1)  q <= q + W'(1);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Front-end hazard sequencer: load-use stalls, branch flushes and multi-cycle EX holds.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_CYCLES  = 4,
  parameter int BR_PENALTY = 1,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hif
);
  localparam int CNT_MAX = imax(MC_CYCLES, BR_PENALTY);
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  haz_state_t    state;
  logic [CW-1:0] cnt;
  logic          load_use, is_mul;

  assign is_mul   = (hif.IDEX_OPCODE == OP_MUL);
  // rd is only 3 bits wide, so registers 8..15 can never alias it
  assign load_use = (hif.IDEX_OPCODE == OP_LOAD) && (hif.IDEX_RD_ADDR != 3'd0) &&
                    (hif.IFID_OPCODE != OP_NOP) &&
                    (({1'b0, hif.IDEX_RD_ADDR} == hif.IFID_R1_ADDR) ||
                     ({1'b0, hif.IDEX_RD_ADDR} == hif.IFID_R2_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hif.BRANCH_TAKEN) begin
            if (BR_PENALTY > 1) begin
              state <= FLUSH;
              cnt   <= CW'(BR_PENALTY - 2);
            end
          end else if (is_mul) begin
            state <= MC_WAIT;
            cnt   <= CW'(MC_CYCLES - 2);
          end
        end
        FLUSH, MC_WAIT: begin
          if (cnt == '0) state <= RUN;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    hif.PC_WE      = 1'b1;
    hif.IFID_STALL = 1'b0;
    hif.IFID_FLUSH = 1'b0;
    hif.IDEX_FLUSH = 1'b0;
    hif.EX_HOLD    = 1'b0;
    if (rst) begin
      hif.PC_WE      = 1'b0;
      hif.IFID_FLUSH = 1'b1;
      hif.IDEX_FLUSH = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (hif.BRANCH_TAKEN) begin
            hif.IFID_FLUSH = 1'b1;
            hif.IDEX_FLUSH = 1'b1;
          end else if (is_mul) begin
            hif.PC_WE      = 1'b0;
            hif.IFID_STALL = 1'b1;
            hif.EX_HOLD    = 1'b1;
          end else if (load_use) begin
            hif.PC_WE      = 1'b0;
            hif.IFID_STALL = 1'b1;
            hif.IDEX_FLUSH = 1'b1;
          end
        end
        FLUSH: hif.IFID_FLUSH = 1'b1;
        MC_WAIT: begin
          if (cnt != '0) begin
            hif.PC_WE      = 1'b0;
            hif.IFID_STALL = 1'b1;
            hif.EX_HOLD    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hif.HAZ_STATE = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (!hif.PC_WE),
    .q   (hif.STALL_CNT)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: dut0 default config, dut1 with BR_PENALTY=3 and a 4-bit stall counter.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) if0 ();
  hazard_ctrl_if #(.CNT_W(4))  if1 ();

  hazard_ctrl #(.MC_CYCLES(4), .BR_PENALTY(1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .hif(if0.slave));
  hazard_ctrl #(.MC_CYCLES(4), .BR_PENALTY(3), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .hif(if1.slave));

  // control vectors: {PC_WE, IFID_STALL, IFID_FLUSH, IDEX_FLUSH, EX_HOLD}
  localparam logic [4:0] C_DEF = 5'b10000;
  localparam logic [4:0] C_RST = 5'b00110;
  localparam logic [4:0] C_LU  = 5'b01010;
  localparam logic [4:0] C_MUL = 5'b01001;
  localparam logic [4:0] C_BR  = 5'b10110;
  localparam logic [4:0] C_FL  = 5'b10100;
  localparam opcode_t    OP_ALU = 5'h01;

  typedef struct {
    string      tag;
    bit         sel;
    logic [4:0] ctl;
    logic [1:0] st;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input opcode_t ifop, input logic [3:0] r1, input logic [3:0] r2,
                       input opcode_t exop, input logic [2:0] rd, input bit br);
    rst = r;
    if0.IFID_OPCODE = ifop; if0.IFID_R1_ADDR = r1; if0.IFID_R2_ADDR = r2;
    if0.IDEX_OPCODE = exop; if0.IDEX_RD_ADDR = rd; if0.BRANCH_TAKEN = br;
    if1.IFID_OPCODE = ifop; if1.IFID_R1_ADDR = r1; if1.IFID_R2_ADDR = r2;
    if1.IDEX_OPCODE = exop; if1.IDEX_RD_ADDR = rd; if1.BRANCH_TAKEN = br;
  endtask

  task automatic step(input string tag, input bit sel, input bit r, input opcode_t ifop,
                      input logic [3:0] r1, input logic [3:0] r2, input opcode_t exop,
                      input logic [2:0] rd, input bit br,
                      input logic [4:0] ctl, input logic [1:0] st, input int cnt);
    exp_t e;
    @(posedge clk); #1;
    drive(r, ifop, r1, r2, exop, rd, br);
    e.tag = tag; e.sel = sel; e.ctl = ctl; e.st = st; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic nop(input string tag, input bit sel, input logic [1:0] st, input int cnt);
    step(tag, sel, 1'b0, OP_NOP, 4'h0, 4'h0, OP_NOP, 3'd0, 1'b0, C_DEF, st, cnt);
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(posedge clk); #1;
      drive(1'b1, OP_NOP, 4'h0, 4'h0, OP_NOP, 3'd0, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [4:0] ctl;
      logic [1:0] st;
      logic [31:0] cnt;
      e = sb.pop_front();
      if (e.sel) begin
        ctl = {if1.PC_WE, if1.IFID_STALL, if1.IFID_FLUSH, if1.IDEX_FLUSH, if1.EX_HOLD};
        st  = if1.HAZ_STATE; cnt = 32'(if1.STALL_CNT);
      end else begin
        ctl = {if0.PC_WE, if0.IFID_STALL, if0.IFID_FLUSH, if0.IDEX_FLUSH, if0.EX_HOLD};
        st  = if0.HAZ_STATE; cnt = 32'(if0.STALL_CNT);
      end
      chk({e.tag, "_ctl"}, 32'(ctl), 32'(e.ctl));
      chk({e.tag, "_st"},  32'(st),  32'(e.st));
      chk({e.tag, "_cnt"}, cnt,      32'(e.cnt));
      chk({e.tag, "_excl"}, 32'(ctl[3] & ctl[2]), 32'd0);
    end
  end

  initial begin
    drive(1'b1, OP_NOP, 4'h0, 4'h0, OP_NOP, 3'd0, 1'b0);
    // T1: reset then idle stream
    step("t1_rst0", 0, 1'b1, OP_NOP, 4'h0, 4'h0, OP_NOP, 3'd0, 1'b0, C_RST, 2'd0, 0);
    step("t1_rst1", 1, 1'b1, OP_NOP, 4'h0, 4'h0, OP_NOP, 3'd0, 1'b0, C_RST, 2'd0, 0);
    nop("t1_nop0", 0, 2'd0, 0);
    nop("t1_nop1", 0, 2'd0, 0);
    nop("t1_nop2", 1, 2'd0, 0);
    // T2: load-use variants
    step("t2_lu_r2",  0, 0, OP_ALU, 4'h5, 4'h3, OP_LOAD, 3'd3, 0, C_LU,  2'd0, 0);
    step("t2_after",  0, 0, OP_ALU, 4'h5, 4'h3, OP_NOP,  3'd0, 0, C_DEF, 2'd0, 1);
    step("t2_rd0",    0, 0, OP_ALU, 4'h0, 4'h0, OP_LOAD, 3'd0, 0, C_DEF, 2'd0, 1);
    step("t2_ifnop",  0, 0, OP_NOP, 4'h3, 4'h3, OP_LOAD, 3'd3, 0, C_DEF, 2'd0, 1);
    step("t2_lu_r1",  0, 0, OP_ALU, 4'h5, 4'h0, OP_LOAD, 3'd5, 0, C_LU,  2'd0, 1);
    step("t2_hibit",  0, 0, OP_ALU, 4'hb, 4'hb, OP_LOAD, 3'd3, 0, C_DEF, 2'd0, 2);
    // T3: single MUL, branch ignored while waiting
    step("t3_m0", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_MUL, 2'd0, 2);
    step("t3_m1", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 1, C_MUL, 2'd2, 3);
    step("t3_m2", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_MUL, 2'd2, 4);
    step("t3_m3", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_DEF, 2'd2, 5);
    nop("t3_done", 0, 2'd0, 5);
    // back-to-back MUL: 6 stalls total
    step("t3_bb0", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_MUL, 2'd0, 5);
    step("t3_bb1", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_MUL, 2'd2, 6);
    step("t3_bb2", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_MUL, 2'd2, 7);
    step("t3_bb3", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_DEF, 2'd2, 8);
    step("t3_bb4", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd2, 0, C_MUL, 2'd0, 8);
    step("t3_bb5", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd2, 0, C_MUL, 2'd2, 9);
    step("t3_bb6", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd2, 0, C_MUL, 2'd2, 10);
    step("t3_bb7", 0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd2, 0, C_DEF, 2'd2, 11);
    nop("t3_bbdone", 0, 2'd0, 11);
    // T4: branch beats load-use (penalty 1)
    step("t4_br", 0, 0, OP_ALU, 4'h0, 4'h3, OP_LOAD, 3'd3, 1, C_BR, 2'd0, 11);
    nop("t4_after", 0, 2'd0, 11);
    // T5: reset on the 2nd MC_WAIT cycle
    step("t5_m0",  0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_MUL, 2'd0, 11);
    step("t5_m1",  0, 0, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_MUL, 2'd2, 12);
    step("t5_rst", 0, 1, OP_ALU, 4'h1, 4'h2, OP_MUL, 3'd1, 0, C_RST, 2'd2, 13);
    step("t5_post", 0, 0, OP_ALU, 4'h1, 4'h2, OP_NOP, 3'd1, 0, C_DEF, 2'd0, 0);
    // T4b on dut1: penalty 3, load-use ignored during FLUSH
    do_reset();
    step("t4b_br", 1, 0, OP_ALU, 4'h0, 4'h3, OP_LOAD, 3'd3, 1, C_BR, 2'd0, 0);
    step("t4b_f1", 1, 0, OP_ALU, 4'h0, 4'h3, OP_LOAD, 3'd3, 0, C_FL, 2'd1, 0);
    step("t4b_f2", 1, 0, OP_ALU, 4'h0, 4'h3, OP_MUL,  3'd3, 0, C_FL, 2'd1, 0);
    nop("t4b_run", 1, 2'd0, 0);
    // T6 on dut1: 4-bit counter saturates
    for (int i = 0; i < 20; i++)
      step($sformatf("t6_lu%0d", i), 1, 0, OP_ALU, 4'h3, 4'h3, OP_LOAD, 3'd3, 0, C_LU, 2'd0,
           (i > 15) ? 15 : i);
    nop("t6_sat", 1, 2'd0, 15);
    @(posedge clk);
    @(posedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
